// File: rtl/msg_symbol_streamer.sv
// Snapshots a right-aligned packed ASCII string, finds its length (optionally dropping a
// trailing newline) and streams it MSB-first as SYM_W-bit symbols over valid/ready.
module msg_symbol_streamer #(
    parameter int STRING_LEN = 512,
    parameter int SYM_W      = 2,
    parameter int TERM_EN    = 1,
    parameter int STRIP_NL   = 1,
    parameter int LW         = $clog2(STRING_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [8*STRING_LEN-1:0] hiding_string,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic [SYM_W-1:0]        sym_data,
    output logic                    sym_last,
    output logic [LW-1:0]           char_idx,
    output logic [LW-1:0]           msg_len,
    output logic                    empty_msg,
    output logic                    busy,
    output logic                    done
);

    localparam int SPC  = 8 / SYM_W;
    localparam int SUBW = (SPC > 1) ? $clog2(SPC) : 1;
    localparam int IW   = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
    localparam int CW   = $clog2((STRING_LEN + 1) * SPC + 1);

    typedef enum logic [1:0] {IDLE, SCAN, STREAM, DONE} state_e;

    state_e                     state_q, state_d;
    logic [STRING_LEN-1:0][7:0] snap_q, snap_d;
    // Scan pointer; once the scan ends it holds the byte index of the first character.
    logic [IW-1:0]              ptr_q, ptr_d;
    logic [LW-1:0]              cidx_q, cidx_d;
    logic [LW-1:0]              msg_len_q, msg_len_d;
    logic                       empty_q, empty_d;
    logic                       vld_q, vld_d;
    logic [SUBW-1:0]            sub_q, sub_d;
    logic [CW-1:0]              rem_q, rem_d;

    logic [7:0]    scan_byte, cur_char, shifted;
    logic [LW-1:0] raw_len, len_tmp;
    logic [CW-1:0] n_sym;
    logic [IW-1:0] byte_idx;
    logic          fire;

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        ptr_d     = ptr_q;
        cidx_d    = cidx_q;
        msg_len_d = msg_len_q;
        empty_d   = empty_q;
        vld_d     = vld_q;
        sub_d     = sub_q;
        rem_d     = rem_q;

        scan_byte = snap_q[ptr_q];
        raw_len   = (scan_byte != 8'h00) ? LW'(ptr_q) + LW'(1) : '0;
        len_tmp   = raw_len - LW'((STRIP_NL != 0) && (raw_len != '0) && (snap_q[0] == 8'h0A));
        n_sym     = (CW'(len_tmp) + CW'(TERM_EN)) * CW'(SPC);

        // Characters past msg_len are the terminator (or a stripped newline): send zero.
        byte_idx  = IW'(LW'(ptr_q) - cidx_q);
        cur_char  = (cidx_q < msg_len_q) ? snap_q[byte_idx] : 8'h00;
        shifted   = cur_char << (SYM_W * int'(sub_q));
        fire      = vld_q && sym_ready;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    snap_d    = hiding_string;
                    ptr_d     = IW'(STRING_LEN - 1);
                    msg_len_d = '0;
                    empty_d   = 1'b0;
                    cidx_d    = '0;
                    sub_d     = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if ((scan_byte != 8'h00) || (ptr_q == '0)) begin
                    msg_len_d = len_tmp;
                    empty_d   = (len_tmp == '0);
                    rem_d     = n_sym;
                    if (n_sym == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = STREAM;
                        vld_d   = 1'b1;
                    end
                end else begin
                    ptr_d = ptr_q - IW'(1);
                end
            end
            STREAM: begin
                if (fire) begin
                    if (rem_q == CW'(1)) begin
                        vld_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        rem_d = rem_q - CW'(1);
                        if (sub_q == SUBW'(SPC - 1)) begin
                            sub_d  = '0;
                            cidx_d = cidx_q + LW'(1);
                        end else begin
                            sub_d = sub_q + SUBW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            ptr_q     <= '0;
            cidx_q    <= '0;
            msg_len_q <= '0;
            empty_q   <= 1'b0;
            vld_q     <= 1'b0;
            sub_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            ptr_q     <= ptr_d;
            cidx_q    <= cidx_d;
            msg_len_q <= msg_len_d;
            empty_q   <= empty_d;
            vld_q     <= vld_d;
            sub_q     <= sub_d;
            rem_q     <= rem_d;
        end
    end

    assign sym_valid = vld_q;
    assign sym_data  = vld_q ? shifted[7:8-SYM_W] : '0;
    assign sym_last  = vld_q && (rem_q == CW'(1));
    assign char_idx  = cidx_q;
    assign msg_len   = msg_len_q;
    assign empty_msg = empty_q;
    assign busy      = (state_q == SCAN) || (state_q == STREAM);
    assign done      = (state_q == DONE);

endmodule
